// File: rtl/stream2sync_if.sv
// AXI-stream pixel channel between a video source and the sync generator.
interface stream2sync_if;
  logic        tvalid;
  logic        tready;
  logic [23:0] tdata;
  logic        tlast;  // last pixel of frame
  logic        tuser;  // last pixel of line

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/stream2sync.sv
// Converts an AXI pixel stream into a timed video output with hsync/vsync.
// Stream is locked to the raster by dropping until TLAST and waiting for frame start.
module stream2sync #(
  parameter bit OPT_INVERT_HSYNC = 1'b1,
  parameter bit OPT_INVERT_VSYNC = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  stream2sync_if.slave s_axis,
  input  logic [15:0]  i_width,
  input  logic [15:0]  i_hfront,
  input  logic [15:0]  i_hsync,
  input  logic [15:0]  i_raw_width,
  input  logic [15:0]  i_height,
  input  logic [15:0]  i_vfront,
  input  logic [15:0]  i_vsync,
  input  logic [15:0]  i_raw_height,
  output logic         o_pix_valid,
  output logic         o_hsync,
  output logic         o_vsync,
  output logic [23:0]  o_pixel,
  output logic         o_locked,
  output logic         o_underflow,
  output logic         o_error
);

  typedef enum logic [1:0] {StDrop, StWait, StRun} state_e;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] hfront;
    logic [15:0] hsync;
    logic [15:0] raw_width;
    logic [15:0] height;
    logic [15:0] vfront;
    logic [15:0] vsync;
    logic [15:0] raw_height;
  } mode_t;

  state_e      state_q, state_d;
  mode_t       mode_q, mode_d, mode_in;
  logic [15:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic [15:0] hlast, vlast;
  logic        hwrap, vwrap, frame_wrap;
  logic        active, hs, vs, line_end, frame_end, accept, ready;
  logic        pix_valid_q, pix_valid_d;
  logic [23:0] pixel_q, pixel_d;
  logic        hsync_q, hsync_d, vsync_q, vsync_d;
  logic        underflow_q, underflow_d, error_q, error_d;

  assign mode_in = {i_width, i_hfront, i_hsync, i_raw_width,
                    i_height, i_vfront, i_vsync, i_raw_height};

  // Raster counters, shadow mode reload at frame wrap, and decoded timing.
  always_comb begin
    // A programmed total of 0 counts as 1.
    hlast      = (mode_q.raw_width == 16'd0) ? 16'd0 : mode_q.raw_width - 16'd1;
    vlast      = (mode_q.raw_height == 16'd0) ? 16'd0 : mode_q.raw_height - 16'd1;
    hwrap      = (hpos_q >= hlast);
    vwrap      = (vpos_q >= vlast);
    frame_wrap = hwrap && vwrap;
    hpos_d     = hwrap ? 16'd0 : hpos_q + 16'd1;
    vpos_d     = vpos_q;
    if (hwrap) begin
      vpos_d = vwrap ? 16'd0 : vpos_q + 16'd1;
    end
    mode_d    = frame_wrap ? mode_in : mode_q;
    active    = (hpos_q < mode_q.width) && (vpos_q < mode_q.height);
    hs        = (hpos_q >= mode_q.hfront) && (hpos_q < mode_q.hsync);
    vs        = (vpos_q >= mode_q.vfront) && (vpos_q < mode_q.vsync);
    line_end  = (hpos_q == mode_q.width - 16'd1);
    frame_end = line_end && (vpos_q == mode_q.height - 16'd1);
    hsync_d   = OPT_INVERT_HSYNC ^ hs;
    vsync_d   = OPT_INVERT_VSYNC ^ vs;
  end

  // Ready depends only on state and raster position, never on TVALID.
  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      StDrop:  ready = 1'b1;
      StWait:  ready = 1'b0;
      StRun:   ready = active;
      default: ready = 1'b0;
    endcase
  end

  assign s_axis.tready = ready;
  assign accept        = s_axis.tvalid && ready;

  // Lock FSM next state plus registered pixel/underflow/error outputs.
  always_comb begin
    state_d     = state_q;
    pix_valid_d = 1'b0;
    pixel_d     = 24'd0;
    underflow_d = 1'b0;
    error_d     = 1'b0;
    unique case (state_q)
      StDrop: begin
        if (accept && s_axis.tlast) state_d = StWait;
      end
      StWait: begin
        // Enter run as counters wrap so the first run cycle sits at pixel (0,0).
        if (frame_wrap) state_d = StRun;
      end
      StRun: begin
        if (active) begin
          pix_valid_d = 1'b1;
          if (s_axis.tvalid) begin
            pixel_d = s_axis.tdata;
            if ((s_axis.tuser != line_end) || (s_axis.tlast != frame_end)) begin
              error_d = 1'b1;
              state_d = s_axis.tlast ? StWait : StDrop;
            end
          end else begin
            underflow_d = 1'b1;
            state_d     = StDrop;
          end
        end
      end
      default: state_d = StDrop;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= StDrop;
      mode_q      <= mode_in;
      hpos_q      <= 16'd0;
      vpos_q      <= 16'd0;
      pix_valid_q <= 1'b0;
      pixel_q     <= 24'd0;
      hsync_q     <= OPT_INVERT_HSYNC;
      vsync_q     <= OPT_INVERT_VSYNC;
      underflow_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      pix_valid_q <= pix_valid_d;
      pixel_q     <= pixel_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      underflow_q <= underflow_d;
      error_q     <= error_d;
    end
  end

  assign o_pix_valid = pix_valid_q;
  assign o_pixel     = pixel_q;
  assign o_hsync     = hsync_q;
  assign o_vsync     = vsync_q;
  assign o_underflow = underflow_q;
  assign o_error     = error_q;
  assign o_locked    = (state_q == StRun);

endmodule
